ex_mem_pipe_reg: RTL and testbench
==================================

EX_MEM_PIPE_REG -- requirements
Module: ex_mem_pipe_reg

Interface
REQ-001 Parameter DATA_W, default 32, sets the width of the ALU result and store-data paths.
REQ-002 Parameter REG_AW, default 5, sets the width of the destination register index.
REQ-003 Parameter SKID_EN, default 1: 1 selects the two-entry skid mode, 0 selects the single-entry mode.
REQ-004 iClk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 iRstN  in  1  synchronous reset, active low.
REQ-006 iFlush  in  1  synchronous discard of all held entries.
REQ-007 iValidE  in  1  EX stage presents an instruction.
REQ-008 oReadyE  out  1  block can accept from EX this cycle.
REQ-009 iRegWriteE, iMemToRegE, iMemWriteE  in  1 each  EX control bits.
REQ-010 iALUOutE  in  DATA_W  ALU result.
REQ-011 iWriteDataE  in  DATA_W  store data.
REQ-012 iWriteRegE  in  REG_AW  destination register index.
REQ-013 oValidM  out  1  MEM entry is valid.
REQ-014 iReadyM  in  1  MEM stage consumes the entry.
REQ-015 oRegWriteM, oMemToRegM, oMemWriteM  out  1 each  MEM control bits.
REQ-016 oALUOutM, oWriteDataM  out  DATA_W  MEM data.
REQ-017 oWriteRegM  out  REG_AW  MEM destination register index.
REQ-018 oCount  out  2  number of held entries (0..2).

Function
REQ-019 Accept SHALL occur when iValidE && oReadyE; handoff SHALL occur when oValidM && iReadyM.
REQ-020 The main entry SHALL drive the M outputs; the skid entry (SKID_EN=1 only) SHALL hold one overflow instruction.
REQ-021 The state SHALL be EMPTY (oCount=0), ONE (1) or TWO (2); TWO SHALL be unreachable when SKID_EN=0.
REQ-022 EMPTY with accept SHALL go to ONE, with main loaded from the E inputs.
REQ-023 ONE with accept and handoff SHALL stay in ONE, with main reloaded from the E inputs.
REQ-024 ONE with accept and no handoff SHALL go to TWO, with skid loaded (SKID_EN=1).
REQ-025 ONE with handoff and no accept SHALL go to EMPTY.
REQ-026 TWO with handoff SHALL go to ONE, with main loaded from skid; TWO SHALL never accept.
REQ-027 When SKID_EN=1, oReadyE SHALL be registered and equal to (next state != TWO), with no combinational path from iReadyM.
REQ-028 When SKID_EN=0, oReadyE SHALL equal !oValidM || iReadyM (combinational).
REQ-029 oValidM SHALL equal (state != EMPTY).
REQ-030 While oValidM && !iReadyM, all M outputs SHALL hold stable.
REQ-031 Ordering SHALL be strict FIFO; no instruction SHALL be dropped or duplicated without a flush.
REQ-032 oRegWriteM and oMemWriteM SHALL be forced to 0 whenever oValidM=0, so a bubble never writes.
REQ-033 An accepted instruction with iWriteRegE=0 SHALL be stored with RegWrite=0 (x0 is never written).
REQ-034 iFlush=1 SHALL force EMPTY on the next edge, discarding any same-cycle accept and ignoring iReadyM; oReadyE SHALL be 1 afterwards.
REQ-035 Under flush, data registers MAY retain stale values, but all gated outputs SHALL be 0.
REQ-036 Latency SHALL be 1 cycle from accept to oValidM with an empty block; throughput SHALL be 1 instruction per cycle while iReadyM=1.

Reset
REQ-037 iRstN=0 at an edge SHALL force EMPTY and oCount=0, overriding iFlush and any handshake.
REQ-038 Reset SHALL clear every M data and control output to 0.
REQ-039 After reset, oReadyE SHALL be 1 from the first cycle with iRstN=1.
REQ-040 A reset asserted mid-stall SHALL discard both held entries.

Verification
REQ-041 Streaming: iReadyM=1, accept ALUOut=0x10,0x20,0x30 on consecutive cycles -> oALUOutM=0x10,0x20,0x30 one cycle later each, oCount stays 1.
REQ-042 Backpressure (SKID_EN=1): iReadyM=0, push 0xA then 0xB -> oCount=2, oReadyE=0, oALUOutM=0xA held; raise iReadyM -> 0xA then 0xB out, oReadyE back to 1.
REQ-043 Flush while TWO with iValidE=1 (0xC) -> next cycle oValidM=0, oCount=0, oRegWriteM=0, oMemWriteM=0, and 0xC never appears.
REQ-044 x0 guard: accept iRegWriteE=1, iWriteRegE=0 -> oRegWriteM=0, oWriteRegM=0; same with iWriteRegE=5 -> oRegWriteM=1.
REQ-045 SKID_EN=0, oValidM=1, iReadyM=0 -> oReadyE=0 in the same cycle; iReadyM=1 -> oReadyE=1 combinationally, and the entry is replaced on the next edge.
REQ-046 iRstN=0 while TWO with iFlush=1 -> all outputs 0, oCount=0; the first cycle after release has oReadyE=1.

Source files
------------

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with valid/ready handshake and an optional skid entry.
// The skid entry lets oReadyE be registered so that iReadyM never reaches EX combinationally.
module ex_mem_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iFlush,
  input  logic              iValidE,
  output logic              oReadyE,
  input  logic              iRegWriteE,
  input  logic              iMemToRegE,
  input  logic              iMemWriteE,
  input  logic [DATA_W-1:0] iALUOutE,
  input  logic [DATA_W-1:0] iWriteDataE,
  input  logic [REG_AW-1:0] iWriteRegE,
  output logic              oValidM,
  input  logic              iReadyM,
  output logic              oRegWriteM,
  output logic              oMemToRegM,
  output logic              oMemWriteM,
  output logic [DATA_W-1:0] oALUOutM,
  output logic [DATA_W-1:0] oWriteDataM,
  output logic [REG_AW-1:0] oWriteRegM,
  output logic [1:0]        oCount
);

  // state | meaning
  // EMPTY | no entry held, M outputs are a bubble
  // ONE   | main entry valid, drives the M outputs
  // TWO   | main plus skid entry held, EX is stalled
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic              regWrite;
    logic              memToReg;
    logic              memWrite;
    logic [DATA_W-1:0] aluOut;
    logic [DATA_W-1:0] writeData;
    logic [REG_AW-1:0] writeReg;
  } entry_t;

  state_t state;
  entry_t mainQ;
  entry_t skidQ;
  entry_t inE;
  logic   readyQ;
  logic   accept;
  logic   handoff;

  // Writes to x0 are squashed at capture so downstream never sees them.
  always_comb begin
    inE           = '0;
    inE.regWrite  = iRegWriteE && (iWriteRegE != '0);
    inE.memToReg  = iMemToRegE;
    inE.memWrite  = iMemWriteE;
    inE.aluOut    = iALUOutE;
    inE.writeData = iWriteDataE;
    inE.writeReg  = iWriteRegE;
  end

  assign oValidM = (state != EMPTY);
  assign oReadyE = SKID_EN ? readyQ : (!oValidM || iReadyM);
  assign accept  = iValidE && oReadyE;
  assign handoff = oValidM && iReadyM;

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state  <= EMPTY;
      mainQ  <= '0;
      skidQ  <= '0;
      readyQ <= 1'b1;
    end else if (iFlush) begin
      state  <= EMPTY;
      readyQ <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            mainQ <= inE;
            state <= ONE;
          end
        end
        ONE: begin
          if (accept && handoff) begin
            mainQ <= inE;
          end else if (accept) begin
            // Only reachable in skid mode; single-entry mode deasserts ready here.
            if (SKID_EN) begin
              skidQ  <= inE;
              state  <= TWO;
              readyQ <= 1'b0;
            end
          end else if (handoff) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (handoff) begin
            mainQ  <= skidQ;
            state  <= ONE;
            readyQ <= 1'b1;
          end
        end
        default: begin
          state  <= EMPTY;
          readyQ <= 1'b1;
        end
      endcase
    end
  end

  // Bubbles must never write the register file or memory.
  assign oRegWriteM  = oValidM && mainQ.regWrite;
  assign oMemWriteM  = oValidM && mainQ.memWrite;
  assign oMemToRegM  = mainQ.memToReg;
  assign oALUOutM    = mainQ.aluOut;
  assign oWriteDataM = mainQ.writeData;
  assign oWriteRegM  = mainQ.writeReg;
  assign oCount      = state;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench for ex_mem_pipe_reg: skid instance (SKID_EN=1) and single-entry
// instance (SKID_EN=0) share the same stimulus; each task checks its own scenario.
module tb_ex_mem_pipe_reg;

  logic        iClk;
  logic        iRstN;
  logic        iFlush;
  logic        iValidE;
  logic        iRegWriteE;
  logic        iMemToRegE;
  logic        iMemWriteE;
  logic [31:0] iALUOutE;
  logic [31:0] iWriteDataE;
  logic [4:0]  iWriteRegE;
  logic        iReadyM;

  logic        oReadyE, oValidM, oRegWriteM, oMemToRegM, oMemWriteM;
  logic [31:0] oALUOutM, oWriteDataM;
  logic [4:0]  oWriteRegM;
  logic [1:0]  oCount;

  logic        s0ReadyE, s0ValidM, s0RegWriteM, s0MemToRegM, s0MemWriteM;
  logic [31:0] s0ALUOutM, s0WriteDataM;
  logic [4:0]  s0WriteRegM;
  logic [1:0]  s0Count;

  int checks = 0;
  int errors = 0;

  ex_mem_pipe_reg #(.DATA_W(32), .REG_AW(5), .SKID_EN(1'b1)) dutSkid (
    .iClk(iClk), .iRstN(iRstN), .iFlush(iFlush), .iValidE(iValidE), .oReadyE(oReadyE),
    .iRegWriteE(iRegWriteE), .iMemToRegE(iMemToRegE), .iMemWriteE(iMemWriteE),
    .iALUOutE(iALUOutE), .iWriteDataE(iWriteDataE), .iWriteRegE(iWriteRegE),
    .oValidM(oValidM), .iReadyM(iReadyM), .oRegWriteM(oRegWriteM), .oMemToRegM(oMemToRegM),
    .oMemWriteM(oMemWriteM), .oALUOutM(oALUOutM), .oWriteDataM(oWriteDataM),
    .oWriteRegM(oWriteRegM), .oCount(oCount)
  );

  ex_mem_pipe_reg #(.DATA_W(32), .REG_AW(5), .SKID_EN(1'b0)) dutSingle (
    .iClk(iClk), .iRstN(iRstN), .iFlush(iFlush), .iValidE(iValidE), .oReadyE(s0ReadyE),
    .iRegWriteE(iRegWriteE), .iMemToRegE(iMemToRegE), .iMemWriteE(iMemWriteE),
    .iALUOutE(iALUOutE), .iWriteDataE(iWriteDataE), .iWriteRegE(iWriteRegE),
    .oValidM(s0ValidM), .iReadyM(iReadyM), .oRegWriteM(s0RegWriteM), .oMemToRegM(s0MemToRegM),
    .oMemWriteM(s0MemWriteM), .oALUOutM(s0ALUOutM), .oWriteDataM(s0WriteDataM),
    .oWriteRegM(s0WriteRegM), .oCount(s0Count)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic test_reset();
    iRstN = 1'b0; iFlush = 1'b0; iReadyM = 1'b1;
    iValidE = 1'b1; iALUOutE = 32'hDEAD; iWriteDataE = 32'hBEEF;
    iRegWriteE = 1'b1; iMemToRegE = 1'b1; iMemWriteE = 1'b1; iWriteRegE = 5'd3;
    tick(); tick();
    checks++;
    if ({oValidM, oCount, oRegWriteM, oMemWriteM, oMemToRegM, oALUOutM, oWriteDataM, oWriteRegM} !== 75'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b cnt=%0d alu=%h wd=%h wr=%0d expected all zero",
               oValidM, oCount, oALUOutM, oWriteDataM, oWriteRegM);
    end
    checks++;
    if ({s0ValidM, s0Count, s0ALUOutM} !== 35'd0) begin
      errors++;
      $display("FAIL reset_single: got valid=%b cnt=%0d alu=%h expected zero", s0ValidM, s0Count, s0ALUOutM);
    end
    iValidE = 1'b0; iMemToRegE = 1'b0; iMemWriteE = 1'b0;
    iRstN = 1'b1;
    #1;
    checks++;
    if ({oReadyE, s0ReadyE} !== 2'b11) begin
      errors++;
      $display("FAIL reset_ready: got skid=%b single=%b expected 1 1", oReadyE, s0ReadyE);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] vec [3];
    vec = '{32'h10, 32'h20, 32'h30};
    iReadyM = 1'b1; iRegWriteE = 1'b1; iWriteRegE = 5'd3;
    for (int i = 0; i < 3; i++) begin
      iValidE = 1'b1; iALUOutE = vec[i]; iWriteDataE = vec[i] + 32'd100;
      tick();
      checks++;
      if ({oValidM, oCount, oALUOutM, oWriteDataM, oRegWriteM, oWriteRegM, oReadyE} !==
          {1'b1, 2'd1, vec[i], vec[i] + 32'd100, 1'b1, 5'd3, 1'b1}) begin
        errors++;
        $display("FAIL stream_%0d: got valid=%b cnt=%0d alu=%h wd=%h rw=%b wr=%0d rdy=%b expected alu=%h cnt=1",
                 i, oValidM, oCount, oALUOutM, oWriteDataM, oRegWriteM, oWriteRegM, oReadyE, vec[i]);
      end
      checks++;
      if ({s0Count, s0ALUOutM} !== {2'd1, vec[i]}) begin
        errors++;
        $display("FAIL stream_single_%0d: got cnt=%0d alu=%h expected cnt=1 alu=%h", i, s0Count, s0ALUOutM, vec[i]);
      end
    end
    iValidE = 1'b0;
    tick();
    checks++;
    if ({oValidM, oCount, oRegWriteM, s0ValidM, s0RegWriteM} !== 6'd0) begin
      errors++;
      $display("FAIL stream_drain: got valid=%b cnt=%0d rw=%b s0valid=%b s0rw=%b expected 0",
               oValidM, oCount, oRegWriteM, s0ValidM, s0RegWriteM);
    end
  endtask

  task automatic test_backpressure();
    iReadyM = 1'b0; iValidE = 1'b1; iALUOutE = 32'hA;
    tick();
    checks++;
    if ({oCount, oALUOutM, oReadyE} !== {2'd1, 32'hA, 1'b1}) begin
      errors++;
      $display("FAIL bp_first: got cnt=%0d alu=%h rdy=%b expected 1 a 1", oCount, oALUOutM, oReadyE);
    end
    iALUOutE = 32'hB;
    tick();
    checks++;
    if ({oCount, oALUOutM, oReadyE} !== {2'd2, 32'hA, 1'b0}) begin
      errors++;
      $display("FAIL bp_full: got cnt=%0d alu=%h rdy=%b expected 2 a 0", oCount, oALUOutM, oReadyE);
    end
    checks++;
    if ({s0Count, s0ALUOutM} !== {2'd1, 32'hA}) begin
      errors++;
      $display("FAIL bp_single_never_two: got cnt=%0d alu=%h expected 1 a", s0Count, s0ALUOutM);
    end
    iALUOutE = 32'hEE;
    tick();
    checks++;
    if ({oCount, oALUOutM, oReadyE} !== {2'd2, 32'hA, 1'b0}) begin
      errors++;
      $display("FAIL bp_hold: got cnt=%0d alu=%h rdy=%b expected 2 a 0", oCount, oALUOutM, oReadyE);
    end
    iValidE = 1'b0; iReadyM = 1'b1;
    tick();
    checks++;
    if ({oValidM, oCount, oALUOutM, oReadyE} !== {1'b1, 2'd1, 32'hB, 1'b1}) begin
      errors++;
      $display("FAIL bp_release: got valid=%b cnt=%0d alu=%h rdy=%b expected 1 1 b 1",
               oValidM, oCount, oALUOutM, oReadyE);
    end
    tick();
    checks++;
    if ({oValidM, oCount} !== 3'd0) begin
      errors++;
      $display("FAIL bp_empty: got valid=%b cnt=%0d expected 0 0", oValidM, oCount);
    end
  endtask

  task automatic test_flush();
    iReadyM = 1'b0; iValidE = 1'b1; iRegWriteE = 1'b1; iMemWriteE = 1'b1; iWriteRegE = 5'd7;
    iALUOutE = 32'h1;
    tick();
    iALUOutE = 32'h2;
    tick();
    checks++;
    if (oCount !== 2'd2) begin
      errors++;
      $display("FAIL flush_setup: got cnt=%0d expected 2", oCount);
    end
    iALUOutE = 32'hC; iFlush = 1'b1; iReadyM = 1'b1;
    tick();
    checks++;
    if ({oValidM, oCount, oRegWriteM, oMemWriteM, oReadyE} !== {1'b0, 2'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL flush_skid: got valid=%b cnt=%0d rw=%b mw=%b rdy=%b expected 0 0 0 0 1",
               oValidM, oCount, oRegWriteM, oMemWriteM, oReadyE);
    end
    checks++;
    if ({s0ValidM, s0Count, s0RegWriteM, s0MemWriteM} !== 5'd0) begin
      errors++;
      $display("FAIL flush_single: got valid=%b cnt=%0d rw=%b mw=%b expected 0",
               s0ValidM, s0Count, s0RegWriteM, s0MemWriteM);
    end
    iFlush = 1'b0; iValidE = 1'b0; iMemWriteE = 1'b0;
    tick();
    checks++;
    if (oValidM !== 1'b0 || oALUOutM === 32'hC || s0ALUOutM === 32'hC) begin
      errors++;
      $display("FAIL flush_discard: got valid=%b alu=%h s0alu=%h expected valid 0 and alu not c",
               oValidM, oALUOutM, s0ALUOutM);
    end
  endtask

  task automatic test_x0_guard();
    iReadyM = 1'b1; iValidE = 1'b1; iRegWriteE = 1'b1; iWriteRegE = 5'd0; iALUOutE = 32'h44;
    tick();
    checks++;
    if ({oValidM, oRegWriteM, oWriteRegM, s0RegWriteM} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL x0_guard: got valid=%b rw=%b wr=%0d s0rw=%b expected 1 0 0 0",
               oValidM, oRegWriteM, oWriteRegM, s0RegWriteM);
    end
    iWriteRegE = 5'd5;
    tick();
    checks++;
    if ({oValidM, oRegWriteM, oWriteRegM, s0RegWriteM} !== {1'b1, 1'b1, 5'd5, 1'b1}) begin
      errors++;
      $display("FAIL x5_write: got valid=%b rw=%b wr=%0d s0rw=%b expected 1 1 5 1",
               oValidM, oRegWriteM, oWriteRegM, s0RegWriteM);
    end
    iValidE = 1'b0;
    tick();
  endtask

  task automatic test_single_entry();
    iReadyM = 1'b0; iValidE = 1'b1; iALUOutE = 32'h55;
    tick();
    checks++;
    if ({s0ValidM, s0Count, s0ALUOutM} !== {1'b1, 2'd1, 32'h55}) begin
      errors++;
      $display("FAIL single_load: got valid=%b cnt=%0d alu=%h expected 1 1 55", s0ValidM, s0Count, s0ALUOutM);
    end
    iALUOutE = 32'h77;
    #1;
    checks++;
    if (s0ReadyE !== 1'b0) begin
      errors++;
      $display("FAIL single_stall_ready: got %b expected 0", s0ReadyE);
    end
    tick();
    checks++;
    if ({s0Count, s0ALUOutM} !== {2'd1, 32'h55}) begin
      errors++;
      $display("FAIL single_hold: got cnt=%0d alu=%h expected 1 55", s0Count, s0ALUOutM);
    end
    iALUOutE = 32'h66; iReadyM = 1'b1;
    #1;
    checks++;
    if ({s0ReadyE, oReadyE} !== 2'b10) begin
      errors++;
      $display("FAIL comb_vs_reg_ready: got single=%b skid=%b expected 1 0", s0ReadyE, oReadyE);
    end
    tick();
    checks++;
    if ({s0Count, s0ALUOutM} !== {2'd1, 32'h66}) begin
      errors++;
      $display("FAIL single_replace: got cnt=%0d alu=%h expected 1 66", s0Count, s0ALUOutM);
    end
    iValidE = 1'b0; iFlush = 1'b1;
    tick();
    iFlush = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    iReadyM = 1'b0; iValidE = 1'b1; iRegWriteE = 1'b1; iMemWriteE = 1'b1; iMemToRegE = 1'b1;
    iWriteRegE = 5'd9; iALUOutE = 32'h81; iWriteDataE = 32'h91;
    tick();
    iALUOutE = 32'h82;
    tick();
    checks++;
    if (oCount !== 2'd2) begin
      errors++;
      $display("FAIL rst_stall_setup: got cnt=%0d expected 2", oCount);
    end
    iRstN = 1'b0; iFlush = 1'b1; iReadyM = 1'b1;
    tick();
    checks++;
    if ({oValidM, oCount, oRegWriteM, oMemWriteM, oMemToRegM, oALUOutM, oWriteDataM, oWriteRegM} !== 75'd0) begin
      errors++;
      $display("FAIL rst_stall_outputs: got valid=%b cnt=%0d mtr=%b alu=%h wd=%h wr=%0d expected all zero",
               oValidM, oCount, oMemToRegM, oALUOutM, oWriteDataM, oWriteRegM);
    end
    iRstN = 1'b1; iFlush = 1'b0; iValidE = 1'b0;
    iMemWriteE = 1'b0; iMemToRegE = 1'b0;
    #1;
    checks++;
    if (oReadyE !== 1'b1) begin
      errors++;
      $display("FAIL rst_stall_ready: got %b expected 1", oReadyE);
    end
    tick();
    checks++;
    if ({oValidM, oCount, s0ValidM} !== 4'd0) begin
      errors++;
      $display("FAIL rst_stall_discard: got valid=%b cnt=%0d s0valid=%b expected 0", oValidM, oCount, s0ValidM);
    end
  endtask

  initial begin
    iRstN = 1'b0; iFlush = 1'b0; iValidE = 1'b0; iRegWriteE = 1'b0; iMemToRegE = 1'b0;
    iMemWriteE = 1'b0; iALUOutE = '0; iWriteDataE = '0; iWriteRegE = '0; iReadyM = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_x0_guard();
    test_single_entry();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
